// File: rtl/calc_entry_unit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : calc_entry_unit
// Description : Operand-entry front end of the 8-bit add/subtract calculator.
//               Synchronizes and debounces ENTER, steps A -> B/OP -> compute
//               -> show, and presents a registered two's-complement RESULT.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_entry_unit #(
    parameter int DB_CYCLES = 250000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] SW,
    input  logic       OP,
    input  logic       ENTER,
    output logic [7:0] RESULT,
    output logic       OVF,
    output logic       VALID,
    output logic [1:0] STATE
);

    localparam int                 c_CNT_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CALC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // ENTER conditioning
    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic               r_press;

    // Datapath / FSM state
    state_t     r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_op;
    logic [7:0] r_result;
    logic       r_ovf;
    logic       r_valid;

    state_t     w_state_nxt;
    logic [7:0] w_a_nxt;
    logic [7:0] w_b_nxt;
    logic       w_op_nxt;
    logic [7:0] w_result_nxt;
    logic       w_ovf_nxt;
    logic       w_valid_nxt;

    logic [7:0] w_sum;
    logic [7:0] w_diff;
    logic [7:0] w_calc;
    logic       w_calc_ovf;

    // Synchronize ENTER, accept a level only after DB_CYCLES stable cycles, and
    // pulse press in the cycle right after the accepted level goes high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= ENTER;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_db_cnt == c_CNT_MAX) begin
                    r_stable <= r_sync2;
                    r_db_cnt <= '0;
                    r_press  <= r_sync2;
                end else begin
                    r_db_cnt <= r_db_cnt + c_CNT_ONE;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // 8-bit wrap-around arithmetic and signed overflow for the latched operands
    always_comb begin
        w_sum  = r_a + r_b;
        w_diff = r_a - r_b;
        w_calc = r_op ? w_diff : w_sum;
        if (r_op) begin
            w_calc_ovf = (r_a[7] != r_b[7]) && (w_calc[7] != r_a[7]);
        end else begin
            w_calc_ovf = (r_a[7] == r_b[7]) && (w_calc[7] != r_a[7]);
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_A;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_op     <= 1'b0;
            r_result <= 8'h00;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_result <= w_result_nxt;
            r_ovf    <= w_ovf_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a state says otherwise
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_result_nxt = r_result;
        w_ovf_nxt    = r_ovf;
        w_valid_nxt  = r_valid;
        case (r_state)
            S_A: begin
                w_result_nxt = SW;
                if (r_press) begin
                    w_a_nxt     = SW;
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                w_result_nxt = SW;
                if (r_press) begin
                    w_b_nxt     = SW;
                    w_op_nxt    = OP;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                // A press landing here is intentionally dropped.
                w_result_nxt = w_calc;
                w_ovf_nxt    = w_calc_ovf;
                w_valid_nxt  = 1'b1;
                w_state_nxt  = S_SHOW;
            end
            S_SHOW: begin
                if (r_press) begin
                    w_ovf_nxt   = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_A;
                end
            end
            default: begin
                w_state_nxt = S_A;
            end
        endcase
    end

    assign RESULT = r_result;
    assign OVF    = r_ovf;
    assign VALID  = r_valid;
    assign STATE  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_unit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_calc_entry_unit
// Description : Directed, table-driven bench for calc_entry_unit with
//               DB_CYCLES = 4, plus hand sequences for debounce and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_entry_unit;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       op;
    logic       enter;
    logic [7:0] result;
    logic       ovf;
    logic       valid;
    logic [1:0] state;

    int n_vec;
    int n_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] res;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    calc_entry_unit #(
        .DB_CYCLES(DB)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .SW    (sw),
        .OP    (op),
        .ENTER (enter),
        .RESULT(result),
        .OVF   (ovf),
        .VALID (valid),
        .STATE (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Hold ENTER long enough for one accepted press, then release and let it settle.
    task automatic press();
        enter = 1'b1;
        repeat (DB + 4) @(negedge clk);
        enter = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Full entry of A op B, checks the shown result and that SW/OP are ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic o,
                          input logic [7:0] exp_res, input logic exp_ovf);
        sw = a;
        op = 1'b0;
        press();
        chk("state_after_a", {6'd0, state}, 8'd1);
        sw = b;
        @(negedge clk);
        chk("echo_b", result, b);
        op = o;
        press();
        chk("state_show", {6'd0, state}, 8'd3);
        chk("result", result, exp_res);
        chk("ovf", {7'd0, ovf}, {7'd0, exp_ovf});
        chk("valid", {7'd0, valid}, 8'd1);
        sw = ~b;
        op = ~o;
        repeat (3) @(negedge clk);
        chk("result_hold", result, exp_res);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //            a      b      op    res    ovf
        vecs[0] = '{8'h05, 8'hFD, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h64, 8'h32, 1'b0, 8'h96, 1'b1};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1};
        vecs[3] = '{8'h80, 8'hFF, 1'b1, 8'h81, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b1};
        vecs[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        rst   = 1'b1;
        sw    = 8'h00;
        op    = 1'b0;
        enter = 1'b0;

        // Reset state and first echo
        @(negedge clk);
        sw = 8'h55;
        do_reset(2);
        rst = 1'b1;
        chk("rst_result", result, 8'h00);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_state", {6'd0, state}, 8'd0);
        rst = 1'b0;
        sw  = 8'h2A;
        @(negedge clk);
        chk("echo_2a", result, 8'h2A);

        // Table of arithmetic cases, each followed by a return from S_SHOW
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].ovf);
            press();
            chk("ret_state", {6'd0, state}, 8'd0);
            chk("ret_ovf", {7'd0, ovf}, 8'd0);
            chk("ret_valid", {7'd0, valid}, 8'd0);
            sw = 8'h30 + 8'(i);
            @(negedge clk);
            chk("ret_echo", result, 8'h30 + 8'(i));
        end

        // Too-short ENTER pulse is rejected
        enter = 1'b1;
        repeat (DB - 1) @(negedge clk);
        enter = 1'b0;
        repeat (12) @(negedge clk);
        chk("short_pulse_state", {6'd0, state}, 8'd0);

        // Exact press latency: transition at edge k+2+DB, one transition only
        sw    = 8'h11;
        enter = 1'b1;
        repeat (DB + 2) @(negedge clk);
        chk("latency_before", {6'd0, state}, 8'd0);
        @(negedge clk);
        chk("latency_at", {6'd0, state}, 8'd1);
        repeat (20 - (DB + 3)) @(negedge clk);
        enter = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_one_press", {6'd0, state}, 8'd1);

        // Reset mid-operation, then a fresh entry
        do_reset(2);
        sw = 8'h10;
        press();
        chk("mid_state_b", {6'd0, state}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", {6'd0, state}, 8'd0);
        chk("mid_rst_result", result, 8'h00);
        rst = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // ENTER held across reset release yields a press after debounce
        enter = 1'b1;
        do_reset(2);
        repeat (DB + 6) @(negedge clk);
        chk("held_thru_reset", {6'd0, state}, 8'd1);
        enter = 1'b0;
        repeat (DB + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
